// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit add/sub/logic slice is reused WIDTH times,
// LSB first, with operand/result shift registers, a carry flop and a start/done handshake.
module bitserial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             cy;

    logic             accept, last;
    logic             b_eff, slice_bit, slice_cout, arith;
    logic [WIDTH-1:0] r_next;

    // The 1-bit slice; SUB feeds the inverted B bit into the same full adder.
    always_comb begin
        arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
        b_eff      = (op_q == OP_SUB) ? ~b_sh[0] : b_sh[0];
        slice_bit  = 1'b0;
        slice_cout = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                slice_bit  = a_sh[0] ^ b_eff ^ cy;
                slice_cout = (a_sh[0] & b_eff) | (cy & (a_sh[0] ^ b_eff));
            end
            OP_AND:  slice_bit = a_sh[0] & b_sh[0];
            OP_OR:   slice_bit = a_sh[0] | b_sh[0];
            OP_XOR:  slice_bit = a_sh[0] ^ b_sh[0];
            default: slice_bit = 1'b0;
        endcase
        r_next = {slice_bit, r_sh[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (cnt == LAST);
        busy      = (state == RUN);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            op_q   <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh <= a;
                b_sh <= b;
                r_sh <= '0;
                op_q <= op;
                cnt  <= '0;
                cy   <= (op == OP_SUB);
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                r_sh <= r_next;
                cy   <= arith ? slice_cout : 1'b0;
                // Publish only on the final bit so result/carry stay stable while busy.
                if (last) begin
                    result <= r_next;
                    carry  <= arith ? slice_cout : 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
